chip8_keypad_scanner: RTL and testbench

- Upstream input stage for the chip8 core.
- Scans a 4x4 CHIP-8 hex keypad matrix, synchronises and debounces each key, and presents a 16-bit level vector plus a latched "newest key pressed" value.
- Supports the core's FX0A wait-for-key handshake through clear_newest_key_down.
- Runs on its own scan clock, asynchronous to instruction_clk.

---
 rtl/chip8_keypad_scanner_if.sv | 28 ++
 rtl/chip8_keypad_scanner.sv | 146 ++++++++++++++
 tb/tb_chip8_keypad_scanner.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_keypad_scanner_if.sv
// Purpose : signal bundle between the keypad scanner, the key matrix and the chip8 core.
// Ports   : col_drive (column strobes, active-low), row_sense (row returns, active-low),
//           clear_newest_key_down (core clear request), input_keys (debounced levels),
//           newest_key_down (latest pressed hex key, 16 = none).
//           master = scanner side, slave = matrix/core side.
interface chip8_keypad_scanner_if;
    logic [3:0]  col_drive;
    logic [3:0]  row_sense;
    logic        clear_newest_key_down;
    logic [15:0] input_keys;
    logic [4:0]  newest_key_down;

    modport master (
        output col_drive,
        output input_keys,
        output newest_key_down,
        input  row_sense,
        input  clear_newest_key_down
    );

    modport slave (
        input  col_drive,
        input  input_keys,
        input  newest_key_down,
        output row_sense,
        output clear_newest_key_down
    );
endinterface

// File: rtl/chip8_keypad_scanner.sv
// Purpose : scans a 4x4 CHIP-8 hex keypad, synchronises and debounces every key, and latches
//           the newest pressed key for the core's wait-for-key instruction.
// Ports   : clk, rst_n (async active-low); kp.master carries col_drive / row_sense /
//           clear_newest_key_down / input_keys / newest_key_down. All outputs are registered.
module chip8_keypad_scanner #(
    parameter int SCAN_DIV       = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    chip8_keypad_scanner_if.master kp
);

    localparam int             DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int             CW       = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_SCANS - 1);
    localparam logic [4:0]     NO_KEY   = 5'd16;

    // Physical matrix position to hex key value.
    function automatic logic [3:0] key_of(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hC;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hD;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hE;
            4'hC: k = 4'hA;  4'hD: k = 4'h0;  4'hE: k = 4'hB;  default: k = 4'hF;
        endcase
        return k;
    endfunction

    logic [DW-1:0] div_q, div_d;
    logic [1:0]    col_q, col_d;
    logic [3:0]    col_drive_q, col_drive_d;
    logic [3:0]    row_s1_q, row_s2_q;
    logic [15:0]   raw_q, raw_d;
    logic [15:0]   keys_q, keys_d;
    logic [CW-1:0] cnt_q [16];
    logic [CW-1:0] cnt_d [16];
    logic [4:0]    newest_q, newest_d;
    logic          clr_s1_q, clr_s2_q, clr_prev_q;

    logic          div_end;
    logic          frame_end;
    logic          clr_rise;
    logic [15:0]   press;

    assign div_end   = (div_q == DIV_LAST);
    assign frame_end = div_end && (col_q == 2'd3);
    assign clr_rise  = clr_s2_q && !clr_prev_q;

    // Scan sequencing: divider, column index and the strobe pattern for the next column.
    always_comb begin
        div_d       = div_q + DW'(1);
        col_d       = col_q;
        col_drive_d = col_drive_q;
        if (div_end) begin
            div_d       = '0;
            col_d       = col_q + 2'd1;
            col_drive_d = ~(4'b0001 << (col_q + 2'd1));
        end
    end

    // Raw frame capture. The column-3 capture is folded in combinationally so the
    // frame-completion debounce sees the full frame in the same cycle.
    always_comb begin
        raw_d = raw_q;
        if (div_end) begin
            for (int r = 0; r < 4; r++) begin
                raw_d[key_of(2'(r), col_q)] = ~row_s2_q[r];
            end
        end
    end

    // Per-key debounce: count consecutive disagreeing frames, flip on reaching the limit.
    always_comb begin
        keys_d = keys_q;
        for (int k = 0; k < 16; k++) begin
            cnt_d[k] = cnt_q[k];
            if (frame_end) begin
                if (raw_d[k] == keys_q[k]) begin
                    cnt_d[k] = '0;
                end else if (cnt_q[k] == CNT_LAST) begin
                    keys_d[k] = ~keys_q[k];
                    cnt_d[k]  = '0;
                end else begin
                    cnt_d[k] = cnt_q[k] + CW'(1);
                end
            end
        end
    end

    // Newest key: a press in this cycle overrides a coincident clear; the
    // descending loop leaves the lowest pressed index as the winner.
    always_comb begin
        press    = keys_d & ~keys_q;
        newest_d = newest_q;
        if (clr_rise) begin
            newest_d = NO_KEY;
        end
        for (int k = 15; k >= 0; k--) begin
            if (press[k]) begin
                newest_d = 5'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            col_q       <= '0;
            col_drive_q <= 4'b1110;
            row_s1_q    <= '0;
            row_s2_q    <= '0;
            raw_q       <= '0;
            keys_q      <= '0;
            newest_q    <= NO_KEY;
            clr_s1_q    <= 1'b0;
            clr_s2_q    <= 1'b0;
            clr_prev_q  <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            div_q       <= div_d;
            col_q       <= col_d;
            col_drive_q <= col_drive_d;
            row_s1_q    <= kp.row_sense;
            row_s2_q    <= row_s1_q;
            raw_q       <= raw_d;
            keys_q      <= keys_d;
            newest_q    <= newest_d;
            clr_s1_q    <= kp.clear_newest_key_down;
            clr_s2_q    <= clr_s1_q;
            clr_prev_q  <= clr_s2_q;
            for (int k = 0; k < 16; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign kp.col_drive       = col_drive_q;
    assign kp.input_keys      = keys_q;
    assign kp.newest_key_down = newest_q;

endmodule

// File: tb/tb_chip8_keypad_scanner.sv
// Purpose : self-checking bench for chip8_keypad_scanner with a modelled key matrix,
//           a frame-level reference model and an output-change scoreboard.
// Ports   : none (top level); drives the DUT through chip8_keypad_scanner_if.
module tb_chip8_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    chip8_keypad_scanner_if kp_if ();

    chip8_keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp_if)
    );

    // Hex key at matrix position row*4+col.
    int kmap [16] = '{1, 2, 3, 12, 4, 5, 6, 13, 7, 8, 9, 14, 10, 0, 11, 15};

    logic [15:0] sw = '0;  // closed switches, indexed by hex key

    always_comb begin
        kp_if.row_sense = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (sw[kmap[r*4+c]] && !kp_if.col_drive[c])
                    kp_if.row_sense[r] = 1'b0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Reference model state, advanced once per scan frame.
    logic [15:0] m_keys;
    int          m_run [16];
    int          m_newest;
    logic        clr_lvl;
    logic [20:0] last_exp;
    logic [20:0] exp_q [$];

    bit          mon_en = 1'b0;
    logic [20:0] last_obs;
    int          last_chg_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_if_changed();
        logic [20:0] e;
        e = {m_keys, 5'(m_newest)};
        if (e != last_exp) begin
            exp_q.push_back(e);
            last_exp = e;
        end
    endtask

    task automatic model_reset();
        m_keys   = '0;
        m_newest = 16;
        for (int k = 0; k < 16; k++) m_run[k] = 0;
        last_exp = {16'h0, 5'd16};
        exp_q.delete();
    endtask

    // A key flips once it has disagreed with its debounced level for DB frames in a row.
    task automatic model_frame(input logic [15:0] s, input bit late_rise);
        int low;
        low = 16;
        for (int k = 0; k < 16; k++) begin
            if (s[k] != m_keys[k]) begin
                m_run[k]++;
                if (m_run[k] == DB) begin
                    m_keys[k] = ~m_keys[k];
                    m_run[k]  = 0;
                    if (m_keys[k] && low == 16) low = k;
                end
            end else begin
                m_run[k] = 0;
            end
        end
        if (low != 16) m_newest = low;
        else if (late_rise) m_newest = 16;
        push_if_changed();
    endtask

    task automatic monitor();
        logic [20:0] cur;
        logic [20:0] e;
        forever begin
            @(negedge clk);
            cur = {kp_if.input_keys, kp_if.newest_key_down};
            if (!mon_en) begin
                last_obs = {16'h0, 5'd16};
            end else if (cur != last_obs) begin
                last_obs     = cur;
                last_chg_cyc = cyc;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: got keys=%04h newest=%0d with nothing expected",
                             cur[20:5], cur[4:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (e != cur) begin
                        fails++;
                        $display("FAIL sb_compare: got keys=%04h newest=%0d expected keys=%04h newest=%0d",
                                 cur[20:5], cur[4:0], e[20:5], e[4:0]);
                    end
                end
            end
        end
    endtask

    task automatic wait_frame_start();
        logic [3:0] prev;
        bit found;
        found = 0;
        prev  = kp_if.col_drive;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (kp_if.col_drive == 4'b1110 && prev == 4'b0111) found = 1;
            prev = kp_if.col_drive;
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL frame_sync: no frame boundary within 80 cycles");
        end
    endtask

    int t_clr = 0;

    // Called at the first negedge of a frame; optionally drives clear to clr_v at step clr_at.
    task automatic run_frame(input logic [15:0] s, input int clr_at, input logic clr_v);
        bit late;
        bit rise;
        late = 0;
        sw   = s;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i == clr_at) begin
                rise    = clr_v && !clr_lvl;
                clr_lvl = clr_v;
                kp_if.clear_newest_key_down = clr_v;
                t_clr   = cyc;
                if (rise) begin
                    if (i <= 12) begin
                        m_newest = 16;
                        push_if_changed();
                    end else begin
                        late = 1;
                    end
                end
            end
        end
        model_frame(s, late);
        @(negedge clk);
        chk("frame_align_col", {28'h0, kp_if.col_drive}, 32'hE);
    endtask

    task automatic frames(input logic [15:0] s, input int n);
        for (int i = 0; i < n; i++) run_frame(s, 0, 1'b0);
    endtask

    task automatic check_state(input string nm);
        chk({nm, "_keys"}, {16'h0, kp_if.input_keys}, {16'h0, m_keys});
        chk({nm, "_newest"}, {27'h0, kp_if.newest_key_down}, 32'(m_newest));
    endtask

    initial begin
        int bad;
        int t0;
        int lat;
        logic [15:0] s;
        kp_if.clear_newest_key_down = 1'b0;
        clr_lvl = 1'b0;
        model_reset();
        fork
            monitor();
        join_none

        // 1. reset values, then press key 5 and reset again mid-frame
        repeat (3) @(negedge clk);
        chk("rst_col", {28'h0, kp_if.col_drive}, 32'hE);
        chk("rst_keys", {16'h0, kp_if.input_keys}, 32'h0);
        chk("rst_newest", {27'h0, kp_if.newest_key_down}, 32'd16);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;
        wait_frame_start();
        frames(16'h0020, 3);
        check_state("key5_held");
        sw = 16'h0020;
        repeat (7) @(negedge clk);
        #3;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("async_rst_col", {28'h0, kp_if.col_drive}, 32'hE);
        chk("async_rst_keys", {16'h0, kp_if.input_keys}, 32'h0);
        chk("async_rst_newest", {27'h0, kp_if.newest_key_down}, 32'd16);
        model_reset();
        sw = '0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;
        bad = 0;
        for (int i = 0; i < 10 * 4 * SD; i++) begin
            @(negedge clk);
            if (kp_if.col_drive != ~(4'b0001 << (((i + 1) / SD) % 4))) bad++;
        end
        chk("col_sequence_errors", 32'(bad), 32'd0);
        check_state("idle_10_frames");
        wait_frame_start();

        // 3. bounce on key 9: 1 closed, 1 open, 2 closed, open
        frames(16'h0200, 1);
        frames(16'h0000, 1);
        frames(16'h0200, 2);
        frames(16'h0000, 3);
        chk("bounce_keys", {16'h0, kp_if.input_keys}, 32'h0);
        chk("bounce_newest", {27'h0, kp_if.newest_key_down}, 32'd16);

        // 2. single press of key 6 with latency bound, then release
        t0 = cyc;
        frames(16'h0040, 3);
        lat = last_chg_cyc - t0;
        chk("press6_keys", {16'h0, kp_if.input_keys}, 32'h0040);
        chk("press6_newest", {27'h0, kp_if.newest_key_down}, 32'd6);
        chk("press6_latency_in_bounds", 32'(lat >= 3 * 4 * SD && lat <= (DB + 1) * 4 * SD + 3), 32'd1);
        t0 = cyc;
        frames(16'h0000, 3);
        lat = last_chg_cyc - t0;
        chk("release6_latency_in_bounds", 32'(lat <= (DB + 1) * 4 * SD + 3), 32'd1);
        check_state("release6");
        chk("release6_newest_kept", {27'h0, kp_if.newest_key_down}, 32'd6);

        // 4. clear pulse, then hold clear high and press key A
        run_frame(16'h0000, 2, 1'b1);
        chk("clear_latency", 32'(last_chg_cyc - t_clr), 32'd3);
        chk("clear_newest", {27'h0, kp_if.newest_key_down}, 32'd16);
        frames(16'h0400, 3);
        chk("keyA_keys", {16'h0, kp_if.input_keys}, 32'h0400);
        chk("keyA_newest", {27'h0, kp_if.newest_key_down}, 32'd10);
        run_frame(16'h0000, 2, 1'b0);
        frames(16'h0000, 2);

        // 5. simultaneous keys 1 and F, then key 0 alone
        frames(16'h8002, 3);
        chk("multi_keys", {16'h0, kp_if.input_keys}, 32'h8002);
        chk("multi_newest", {27'h0, kp_if.newest_key_down}, 32'd1);
        frames(16'h0000, 3);
        frames(16'h0001, 3);
        chk("key0_newest", {27'h0, kp_if.newest_key_down}, 32'd0);
        frames(16'h0000, 3);

        // 6. clear rise synchronised onto the frame where key C debounces
        frames(16'h1000, 2);
        run_frame(16'h1000, 13, 1'b1);
        chk("collision_newest", {27'h0, kp_if.newest_key_down}, 32'd12);
        chk("collision_keys", {16'h0, kp_if.input_keys}, 32'h1000);
        run_frame(16'h0000, 2, 1'b0);
        frames(16'h0000, 2);

        // randomized phase: sparse key sets held for 1..5 frames, random clear edges
        for (int g = 0; g < 40; g++) begin
            s = '0;
            if ($urandom_range(0, 4) != 0)
                for (int b = 0; b < 3; b++)
                    if ($urandom_range(0, 1) != 0) s[$urandom_range(0, 15)] = 1'b1;
            for (int f = 0; f < int'($urandom_range(1, 5)); f++) begin
                if ($urandom_range(0, 2) == 0)
                    run_frame(s, ($urandom_range(0, 1) != 0) ? 13 : int'($urandom_range(1, 12)), ~clr_lvl);
                else
                    run_frame(s, 0, 1'b0);
            end
        end
        check_state("random_end");
        frames(16'h0000, 4);
        check_state("final");
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
